// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with PC, fetch buffer, redirect and halt (optional counters: FETCH_PERF_EN)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_mem_q    [FIFO_DEPTH];
  logic [31:0]        pc_mem_d    [FIFO_DEPTH];
  logic [31:0]        instr_mem_q [FIFO_DEPTH];
  logic [31:0]        instr_mem_d [FIFO_DEPTH];
  logic               halted_q, halted_d;

  logic               fifo_full;
  logic               xfer;
  logic               enq;
  logic               redirect_pc_unused;

  // Low address bits of a redirect target are dropped, never used.
  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign fifo_full = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign xfer      = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full buffer still streams.
  assign enq       = (state_q == ST_RUN) && !halt_req && !redirect_valid &&
                     (!fifo_full || xfer);

  assign imem_addr = fetch_pc_q;
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];
  assign halted    = halted_q;

  // Next-state: buffer push/pop, PC advance, redirect flush and run/halt FSM.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (redirect_valid) begin
      // Any coinciding transfer is taken by decode; the rest is discarded.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      if (xfer) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (enq) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        fetch_pc_d            = fetch_pc_q + 32'd4;
      end
      if (xfer && !enq) begin
        count_d = count_q - CNT_W'(1);
      end else if (enq && !xfer) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    if (state_q == ST_RUN) begin
      if (halt_req) begin
        state_d = ST_HALT;
      end
    end else begin
      if (!halt_req) begin
        state_d = ST_RUN;
      end
    end

    halted_d = (state_d == ST_HALT) && (count_d == '0);
  end

  // State register; reset clears the buffer so out_pc/out_instr read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      halted_q    <= halted_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;

  // Count enqueues and cycles where fetch was willing but the buffer was full.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (enq) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
    if ((state_q == ST_RUN) && !halt_req && !redirect_valid && fifo_full && !xfer) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Counter registers, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // addi xn, x0, n style words: 0x00000013, 0x00100093, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [11:0] n;
    n = a[13:2];
    return {n, 5'd0, 3'd0, n[4:0], 7'h13};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        halt;
    logic        rdy;
    logic        e_valid;
    logic        e_halted;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic h, input logic rdy, input logic ev,
                              input logic eh, input logic cp, input logic [31:0] epc,
                              input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.halt = h; v.rdy = rdy;
    v.e_valid = ev; v.e_halted = eh; v.chk_pc = cp; v.e_pc = epc; v.e_addr = ea;
    return v;
  endfunction

  initial begin
    //                  rst rv  rpc            h  rdy val hl cp  pc             addr
    // streaming from reset
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 1, 0, 1, 32'h0,          32'h4));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 1, 0, 1, 32'h4,          32'h8));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 1, 0, 1, 32'h8,          32'hC));
    // synchronous-looking reset, then backpressure for 5 cycles
    tbl.push_back(mk(1, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,          32'h0));
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 1, 0, 1, 32'h0,          32'h4));
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 1, 0, 1, 32'h0,          32'h8));
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 1, 0, 1, 32'h0,          32'h8));
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 1, 0, 1, 32'h0,          32'h8));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 1, 0, 1, 32'h0,          32'h8));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 1, 0, 1, 32'h4,          32'hC));
    // redirect while full, head transfer completes
    tbl.push_back(mk(0, 1, 32'h103,        0, 1, 1, 0, 1, 32'h8,          32'h10));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0,          32'h100));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 1, 0, 1, 32'h100,        32'h104));
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 1, 0, 1, 32'h104,        32'h108));
    // halt for 6 cycles, drain, resume
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 1, 0, 1, 32'h104,        32'h10C));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 1, 0, 1, 32'h108,        32'h10C));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 0, 1, 0, 32'h0,          32'h10C));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 0, 1, 0, 32'h0,          32'h10C));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 0, 1, 0, 32'h0,          32'h10C));
    tbl.push_back(mk(0, 0, 32'h0,          1, 1, 0, 1, 0, 32'h0,          32'h10C));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 0, 1, 0, 32'h0,          32'h10C));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0,          32'h10C));
    // redirect near top of address space, PC wrap
    tbl.push_back(mk(0, 1, 32'hFFFF_FFF8,  0, 1, 1, 0, 1, 32'h10C,        32'h110));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0,          32'hFFFF_FFF8));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 1, 0, 1, 32'hFFFF_FFF8,  32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 1, 0, 1, 32'hFFFF_FFFC,  32'h0));
    // redirect and halt together
    tbl.push_back(mk(0, 1, 32'h200,        1, 1, 1, 0, 1, 32'h0,          32'h4));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 0, 1, 0, 32'h0,          32'h200));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0,          32'h200));
    tbl.push_back(mk(0, 0, 32'h0,          0, 1, 1, 0, 1, 32'h200,        32'h204));

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      halt_req = tbl[i].halt; out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].e_halted});
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      if (tbl[i].chk_pc) begin
        chk($sformatf("v%0d_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_instr", i), out_instr, mem_word(tbl[i].e_pc));
      end
      @(posedge clk); #1;
    end

    // fill the buffer, then reset asynchronously mid-cycle
    redirect_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_pc", out_pc, 32'h204);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // two fetches, three full stalls, then eight streamed fetches
    repeat (5) @(posedge clk);
    #1;
    chk("restart_valid", {31'd0, out_valid}, 32'd1);
    chk("restart_pc", out_pc, 32'h0);
    chk("restart_addr", imem_addr, 32'h8);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    halt_req = 1'b1;
    chk("stream_pc", out_pc, 32'h20);
    chk("stream_instr", out_instr, mem_word(32'h20));
    chk("stream_addr", imem_addr, 32'h28);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd10);
    chk("perf_stall", perf_stall_cnt, 32'd3);
`endif

    // redirect while halted, then resume
    repeat (2) @(posedge clk);
    #1;
    chk("halt2_halted", {31'd0, halted}, 32'd1);
    chk("halt2_addr", imem_addr, 32'h28);
    redirect_valid = 1'b1; redirect_pc = 32'h301;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    chk("hredir_addr", imem_addr, 32'h300);
    chk("hredir_valid", {31'd0, out_valid}, 32'd0);
    chk("hredir_halted", {31'd0, halted}, 32'd1);
    halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("resume_valid", {31'd0, out_valid}, 32'd1);
    chk("resume_pc", out_pc, 32'h300);
    chk("resume_instr", out_instr, mem_word(32'h300));
    chk("resume_addr", imem_addr, 32'h304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
